// File: rtl/onehot_enc16to4_pkg.sv
// Shared widths for the 16-to-4 one-hot encoder.
// Imported by the interface, the checker and the top.
package onehot_enc16to4_pkg;
  localparam int ENC_IN_W  = 16;
  localparam int ENC_OUT_W = 4;
endpackage

// File: rtl/onehot_enc16to4_if.sv
// Encoder bus: select vector in, index/valid/sticky error out.
// master drives in_; slave (the encoder) drives the rest.
interface onehot_enc16to4_if;
  import onehot_enc16to4_pkg::*;
  logic [ENC_IN_W-1:0]  in_;
  logic [ENC_OUT_W-1:0] out;
  logic                 valid;
  logic                 err_seen;
  modport master (
    output in_,
    input  out,
    input  valid,
    input  err_seen
  );
  modport slave (
    input  in_,
    output out,
    output valid,
    output err_seen
  );
endinterface

// File: rtl/onehot_check16.sv
// Exact one-hot detector: in_ (16b) -> valid (1 when one bit set).
// Ports: in_ select vector, valid one-hot flag.
module onehot_check16
  import onehot_enc16to4_pkg::*;
(
  input  logic [ENC_IN_W-1:0] in_,
  output logic                valid
);
  logic seen;
  logic conflict;

  // Scan low to high: a set bit after any earlier set bit
  // is a conflict, so only a single set bit survives.
  always_comb begin
    seen     = 1'b0;
    conflict = 1'b0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      conflict = conflict | (seen & in_[i]);
      seen     = seen | in_[i];
    end
    valid = seen & ~conflict;
  end
endmodule

// File: rtl/onehot_enc16to4.sv
// 16-to-4 one-hot encoder with sticky non-one-hot error flag.
// Ports: clk, reset (sync, active-low), bus (slave: in_/out/valid/err_seen).
module onehot_enc16to4
  import onehot_enc16to4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  onehot_enc16to4_if.slave   bus
);
  logic                 valid;
  logic [ENC_OUT_W-1:0] idx_or;
  logic                 err_seen_d;
  logic                 err_seen_q;

  onehot_check16 u_check (
    .in_   (bus.in_),
    .valid (valid)
  );

  // OR of indices is exact only for one-hot input;
  // valid gates every other case to zero.
  always_comb begin
    idx_or = '0;
    for (int k = 0; k < ENC_IN_W; k++) begin
      if (bus.in_[k]) idx_or = idx_or | 4'(k);
    end
  end

  always_comb begin
    err_seen_d = err_seen_q;
    if (!reset)      err_seen_d = 1'b0;
    else if (!valid) err_seen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    err_seen_q <= err_seen_d;
  end

  assign bus.out      = valid ? idx_or : '0;
  assign bus.valid    = valid;
  assign bus.err_seen = err_seen_q;
endmodule

// File: tb/tb_onehot_enc16to4.sv
// Self-checking bench for onehot_enc16to4.
// Popcount model plus directed literal expectations.
module tb_onehot_enc16to4;
  logic clk;
  logic reset;
  logic chk_en;
  logic em;
  int   pass_cnt;
  int   total_cnt;
  logic [15:0] v;
  logic [15:0] mh [11];

  onehot_enc16to4_if bus ();

  onehot_enc16to4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popc(input logic [15:0] x);
    int n = 0;
    for (int i = 0; i < 16; i++) if (x[i]) n++;
    return n;
  endfunction

  function automatic logic m_valid(input logic [15:0] x);
    return popc(x) == 1;
  endfunction

  function automatic logic [3:0] m_out(input logic [15:0] x);
    logic [3:0] r = 4'd0;
    if (popc(x) != 1) return 4'd0;
    for (int i = 0; i < 16; i++) if (x[i]) r = 4'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(input logic [15:0] x);
    @(posedge clk);
    #1 bus.in_ = x;
    #1;
  endtask

  // sticky flag reference
  always @(posedge clk) begin
    if (!reset) em <= 1'b0;
    else if (!m_valid(bus.in_)) em <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out", 32'(bus.out), 32'(m_out(bus.in_)));
      chk("cyc_valid", 32'(bus.valid), 32'(m_valid(bus.in_)));
      chk("cyc_err", 32'(bus.err_seen), 32'(em));
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    chk_en    = 1'b0;
    reset     = 1'b0;
    bus.in_   = 16'h0001;
    mh = '{16'h0000, 16'h0012, 16'h0024, 16'h0048,
           16'h0110, 16'h8800, 16'h1111, 16'h4444,
           16'hFFFF, 16'h0412, 16'h1048};
    v = 16'($urandom(32'h00C0FFEE));

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_err", 32'(bus.err_seen), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd1);

    for (int k = 0; k < 16; k++) begin
      apply(16'h0001 << k);
      chk("sweep_out", 32'(bus.out), 32'(k));
      chk("sweep_valid", 32'(bus.valid), 32'd1);
      chk("sweep_err", 32'(bus.err_seen), 32'd0);
    end

    apply(16'h0004);
    chk("stk_out2", 32'(bus.out), 32'd2);
    chk("stk_err0", 32'(bus.err_seen), 32'd0);
    apply(16'h0003);
    chk("stk_out_mh", 32'(bus.out), 32'd0);
    chk("stk_valid_mh", 32'(bus.valid), 32'd0);
    apply(16'h0008);
    chk("stk_err1", 32'(bus.err_seen), 32'd1);
    chk("stk_out3", 32'(bus.out), 32'd3);
    @(posedge clk);
    #1 chk("stk_hold", 32'(bus.err_seen), 32'd1);

    for (int i = 0; i < 11; i++) begin
      apply(mh[i]);
      chk("mh_out", 32'(bus.out), 32'd0);
      chk("mh_valid", 32'(bus.valid), 32'd0);
      chk("mh_err", 32'(bus.err_seen), 32'd1);
    end

    apply(16'h0200);
    chk("mid_out_pre", 32'(bus.out), 32'd9);
    chk("mid_err_pre", 32'(bus.err_seen), 32'd1);
    reset = 1'b0;
    #1 chk("mid_out_rst", 32'(bus.out), 32'd9);
    @(posedge clk);
    #1 chk("mid_err_clr", 32'(bus.err_seen), 32'd0);
    chk("mid_out_clr", 32'(bus.out), 32'd9);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("mid_err_post", 32'(bus.err_seen), 32'd0);
    chk("mid_out_post", 32'(bus.out), 32'd9);

    repeat (20) begin
      @(posedge clk);
      #1 v = 16'($urandom);
      bus.in_ = v;
      #8;
      chk("rnd_out", 32'(bus.out), 32'(m_out(v)));
      chk("rnd_valid", 32'(bus.valid), 32'(m_valid(v)));
    end

    @(posedge clk);
    #1 chk_en = 1'b0;
    for (int x = 0; x < 65536; x++) begin
      bus.in_ = 16'(x);
      #1;
      chk("exh", {27'd0, bus.valid, bus.out},
          {27'd0, m_valid(16'(x)), m_out(16'(x))});
    end

    bus.in_ = 16'h0001;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1 chk("final_err", 32'(bus.err_seen), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
